// File: rtl/tdm_demux_4ch.sv
// tdm_demux_4ch: receive side of the 4-slot TDM link; frame-sync aligned slot steering.
// Optional parity check on each word when TDM_DEMUX_PARITY_EN is defined.
module tdm_demux_4ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [1:0]       slot
`ifdef TDM_DEMUX_PARITY_EN
  ,
  input  logic             din_par,
  output logic             par_err
`endif
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic [WIDTH-1:0] sh2;
  logic             bad;
  logic             pe;
  logic             is_idle;
  logic             run_sync;
  logic             run_miss;
  logic             run_mid;
  logic             run_last;
  logic             take;

`ifdef TDM_DEMUX_PARITY_EN
  assign pe = ^{din_par, din};
`else
  assign pe = 1'b0;
`endif

  // Exactly one of these is true each cycle.
  assign is_idle  = (state == IDLE);
  assign run_sync = !is_idle && frame_sync;
  assign run_miss = !is_idle && !frame_sync
                    && (slot == 2'd0);
  assign run_mid  = !is_idle && !frame_sync
                    && (slot == 2'd1 || slot == 2'd2);
  assign run_last = !is_idle && !frame_sync
                    && (slot == 2'd3);
  assign take     = din_valid
                    && (frame_sync || run_mid || run_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      slot        <= 2'd0;
      sh0         <= '0;
      sh1         <= '0;
      sh2         <= '0;
      bad         <= 1'b0;
      o0          <= '0;
      o1          <= '0;
      o2          <= '0;
      o3          <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (din_valid) begin
        unique case (1'b1)
          is_idle: begin
            if (frame_sync) begin
              sh0   <= din;
              bad   <= pe;
              slot  <= 2'd1;
              state <= RUN;
            end
          end
          run_sync: begin
            frame_err <= (slot != 2'd0);
            sh0       <= din;
            bad       <= pe;
            slot      <= 2'd1;
          end
          run_miss: begin
            frame_err <= 1'b1;
            state     <= IDLE;
          end
          run_mid: begin
            if (slot[1]) sh2 <= din;
            else         sh1 <= din;
            bad  <= bad | pe;
            slot <= slot + 2'd1;
          end
          run_last: begin
            slot <= 2'd0;
            if (bad || pe) begin
              frame_err <= 1'b1;
            end else begin
              o0          <= sh0;
              o1          <= sh1;
              o2          <= sh2;
              o3          <= din;
              frame_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) par_err <= 1'b0;
    else        par_err <= take && pe;
  end
`else
  logic unused_take;
  assign unused_take = take;
`endif

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// tb_tdm_demux_4ch: vector table, hand-written corner sequences and a
// randomized run checked against a queue-based frame model.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic       din_par = 1'b0;
  logic [7:0] o0, o1, o2, o3;
  logic       frame_valid, frame_err;
  logic [1:0] slot;
`ifdef TDM_DEMUX_PARITY_EN
  logic       par_err;
`endif

  int total = 0;
  int nbad = 0;

  tdm_demux_4ch #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .frame_sync(frame_sync),
    .o0(o0),
    .o1(o1),
    .o2(o2),
    .o3(o3),
    .frame_valid(frame_valid),
    .frame_err(frame_err),
    .slot(slot)
`ifdef TDM_DEMUX_PARITY_EN
    ,
    .din_par(din_par),
    .par_err(par_err)
`endif
  );

  always #5 clk = ~clk;

  // Reference: words of the current frame are collected in a queue;
  // its length is the next expected slot.
  logic [7:0] m_o[4];
  logic [7:0] m_q[$];
  bit         m_al, m_bad, m_fv, m_fe, m_pe;

  task automatic model(input bit r, input bit v, input bit s,
                       input logic [7:0] d, input bit p);
    bit perr;
`ifdef TDM_DEMUX_PARITY_EN
    perr = ^{p, d};
`else
    perr = 1'b0;
`endif
    m_fv = 0;
    m_fe = 0;
    m_pe = 0;
    if (!r) begin
      foreach (m_o[i]) m_o[i] = '0;
      m_q.delete();
      m_al = 0;
      m_bad = 0;
    end else if (v) begin
      if (s) begin
        m_fe = m_al && (m_q.size() != 0);
        m_q.delete();
        m_q.push_back(d);
        m_bad = perr;
        m_pe = perr;
        m_al = 1;
      end else if (m_al && m_q.size() == 0) begin
        m_fe = 1;
        m_al = 0;
      end else if (m_al) begin
        m_q.push_back(d);
        m_bad = m_bad | perr;
        m_pe = perr;
        if (m_q.size() == 4) begin
          if (m_bad) m_fe = 1;
          else begin
            foreach (m_o[i]) m_o[i] = m_q[i];
            m_fv = 1;
          end
          m_q.delete();
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit s,
                       input logic [7:0] d, input bit flip);
    rst_n = r;
    din_valid = v;
    frame_sync = s;
    din = d;
    din_par = (^d) ^ flip;
    @(posedge clk);
    model(r, v, s, d, din_par);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          r;
    bit          v;
    bit          s;
    logic [7:0]  d;
    logic [31:0] o;
    bit          fv;
    bit          fe;
    logic [1:0]  sl;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit r, bit v, bit s, logic [7:0] d,
                              logic [31:0] o, bit fv, bit fe,
                              logic [1:0] sl);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.d = d;
    t.o = o; t.fv = fv; t.fe = fe; t.sl = sl;
    return t;
  endfunction

  task automatic chk_all(input string tag, input logic [31:0] o,
                         input bit fv, input bit fe,
                         input logic [1:0] sl);
    chk({tag, " out"}, {o0, o1, o2, o3}, o);
    chk({tag, " fv"}, 32'(frame_valid), 32'(fv));
    chk({tag, " fe"}, 32'(frame_err), 32'(fe));
    chk({tag, " slot"}, 32'(slot), 32'(sl));
  endtask

  initial begin
    // reset + basic frame
    tv.push_back(mk(0,0,0,8'h00,32'h0,0,0,0));
    tv.push_back(mk(1,1,1,8'h11,32'h0,0,0,1));
    tv.push_back(mk(1,1,0,8'h22,32'h0,0,0,2));
    tv.push_back(mk(1,1,0,8'h33,32'h0,0,0,3));
    tv.push_back(mk(1,1,0,8'h44,32'h11223344,1,0,0));
    tv.push_back(mk(1,0,0,8'h00,32'h11223344,0,0,0));
    // unsynced words dropped after reset
    tv.push_back(mk(0,0,0,8'h00,32'h0,0,0,0));
    tv.push_back(mk(1,1,0,8'hAA,32'h0,0,0,0));
    tv.push_back(mk(1,1,0,8'hBB,32'h0,0,0,0));
    tv.push_back(mk(1,1,1,8'h55,32'h0,0,0,1));
    tv.push_back(mk(1,1,0,8'h66,32'h0,0,0,2));
    tv.push_back(mk(1,1,0,8'h77,32'h0,0,0,3));
    tv.push_back(mk(1,1,0,8'h88,32'h55667788,1,0,0));
    // early sync
    tv.push_back(mk(1,1,1,8'h01,32'h55667788,0,0,1));
    tv.push_back(mk(1,1,0,8'h02,32'h55667788,0,0,2));
    tv.push_back(mk(1,1,1,8'h10,32'h55667788,0,1,1));
    tv.push_back(mk(1,1,0,8'h20,32'h55667788,0,0,2));
    tv.push_back(mk(1,1,0,8'h30,32'h55667788,0,0,3));
    tv.push_back(mk(1,1,0,8'h40,32'h10203040,1,0,0));
    // missing sync at slot 0, then dropped words
    tv.push_back(mk(1,1,0,8'h99,32'h10203040,0,1,0));
    tv.push_back(mk(1,1,0,8'hA1,32'h10203040,0,0,0));
    tv.push_back(mk(1,1,0,8'hA2,32'h10203040,0,0,0));
    tv.push_back(mk(1,0,1,8'hA3,32'h10203040,0,0,0));

    foreach (tv[i]) begin
      drive(tv[i].r, tv[i].v, tv[i].s, tv[i].d, 0);
      chk_all($sformatf("vec%0d", i), tv[i].o, tv[i].fv,
              tv[i].fe, tv[i].sl);
    end

    // frame with 3-cycle gaps
    drive(1,1,1,8'h11,0);
    for (int k = 0; k < 3; k++) begin
      repeat (3) drive(1,0,0,8'h00,0);
      chk("gap fv", 32'(frame_valid), 32'(0));
      drive(1,1,0,8'h22 + 8'(k) * 8'h11,0);
    end
    chk_all("gap end", 32'h11223344, 1, 0, 0);
    drive(1,0,0,8'h00,0);
    chk("gap fv drop", 32'(frame_valid), 32'(0));

    // reset after slot 2
    drive(1,1,1,8'hAA,0);
    drive(1,1,0,8'hBB,0);
    drive(1,1,0,8'hCC,0);
    chk("pre-rst slot", 32'(slot), 32'(3));
    drive(0,0,0,8'h00,0);
    chk_all("mid rst", 32'h0, 0, 0, 0);
    drive(1,1,0,8'hDD,0);
    chk_all("post rst", 32'h0, 0, 0, 0);

`ifdef TDM_DEMUX_PARITY_EN
    drive(1,1,1,8'h01,0);
    drive(1,1,0,8'h02,0);
    drive(1,1,0,8'h03,0);
    drive(1,1,0,8'h04,0);
    chk_all("par good", 32'h01020304, 1, 0, 0);
    drive(1,1,1,8'h05,0);
    drive(1,1,0,8'h06,1);
    chk("par_err hit", 32'(par_err), 32'(1));
    drive(1,1,0,8'h07,0);
    chk("par_err clr", 32'(par_err), 32'(0));
    drive(1,1,0,8'h08,0);
    chk_all("par bad end", 32'h01020304, 0, 1, 0);
    drive(1,1,1,8'h09,0);
    drive(1,1,0,8'h0A,0);
    drive(1,1,0,8'h0B,0);
    drive(1,1,0,8'h0C,0);
    chk_all("par recover", 32'h090A0B0C, 1, 0, 0);
`endif

    // randomized run against the model
    drive(0,0,0,8'h00,0);
    for (int n = 0; n < 3000; n++) begin
      bit r, v, s, f;
      r = ($urandom_range(0, 149) != 0);
      v = ($urandom_range(0, 99) < 75);
      s = ($urandom_range(0, 99) < 20);
`ifdef TDM_DEMUX_PARITY_EN
      f = ($urandom_range(0, 19) == 0);
`else
      f = 0;
`endif
      drive(r, v, s, 8'($urandom), f);
      chk_all("rnd", {m_o[0], m_o[1], m_o[2], m_o[3]},
              m_fv, m_fe, 2'(m_q.size()));
`ifdef TDM_DEMUX_PARITY_EN
      chk("rnd par_err", 32'(par_err), 32'(m_pe));
`endif
      if (frame_valid && frame_err) begin
        total++;
        nbad++;
        $display("FAIL both pulses: fv=%0b fe=%0b want not both",
                 frame_valid, frame_err);
      end
    end

    $display("test done: total=%0d bad=%0d", total, nbad);
    $finish;
  end

endmodule
